seq_pattern_tx: RTL and testbench

Serial pattern transmitter that produces the bit stream the Moore sequence detector consumes on its `din` input. The block latches a WIDTH-bit pattern and a repeat count on a start request. It then shifts the pattern out MSB-first, one bit per clock, repeating it back-to-back. It flags each driven bit with `valid` and pulses `done` when the burst ends. It sits upstream of the detector in the lab datapath and lets the bench generate long or overlapping detector stimuli from a single command.

---
 rtl/seq_pattern_tx.sv | 113 +++++++++++
 tb/tb_seq_pattern_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a WIDTH-bit pattern and a repeat count on start,
// then shifts the pattern out MSB-first, back-to-back, flagging bits with valid and ending with done.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] count,
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] reload_r;
  logic [REP_W-1:0] rep_r;
  logic [BW-1:0]    bit_r;

  // Burst FSM: shift register holds the current repetition with its MSB already on dout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      shreg_r  <= '0;
      reload_r <= '0;
      rep_r    <= '0;
      bit_r    <= '0;
      dout     <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          dout  <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            if (count != '0) begin
              shreg_r  <= pattern;
              reload_r <= pattern;
              rep_r    <= count;
              bit_r    <= BW'(WIDTH - 1);
              dout     <= pattern[WIDTH-1];
              valid    <= 1'b1;
              busy     <= 1'b1;
              state_r  <= SHIFT;
            end else begin
              busy    <= 1'b1;
              done    <= 1'b1;
              state_r <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        SHIFT: begin
          busy <= 1'b1;
          done <= 1'b0;
          if (bit_r != '0) begin
            shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
            dout    <= shreg_r[WIDTH-2];
            valid   <= 1'b1;
            bit_r   <= bit_r - BW'(1);
          end else if (rep_r > REP_W'(1)) begin
            // Next repetition starts with no gap cycle.
            shreg_r <= reload_r;
            dout    <= reload_r[WIDTH-1];
            valid   <= 1'b1;
            rep_r   <= rep_r - REP_W'(1);
            bit_r   <= BW'(WIDTH - 1);
          end else begin
            dout    <= 1'b0;
            valid   <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end
        end

        DONE: begin
          dout    <= 1'b0;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          dout    <= 1'b0;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx: per-cycle vector table plus
// hand-written repeat, reset and detector-stream sequences.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] count;
  logic       dout;
  logic       valid;
  logic       busy;
  logic       done;

  int n_total;
  int n_pass;

  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] count;
    logic [3:0] exp;   // {dout, valid, busy, done}
  } vec_t;

  vec_t vecs[$];

  seq_pattern_tx #(.WIDTH(8), .REP_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pattern(pattern),
    .count  (count),
    .dout   (dout),
    .valid  (valid),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic s, input logic [7:0] p,
                              input logic [3:0] c, input logic [3:0] e);
    vec_t v;
    v.rst = r; v.start = s; v.pattern = p; v.count = c; v.exp = e;
    vecs.push_back(v);
  endfunction

  // Bit stream of one burst plus its done and idle rows; first bit is on the accepting row.
  function automatic void add_burst(input logic [7:0] p, input logic [3:0] c,
                                    input logic [7:0] p_after, input logic [3:0] c_after,
                                    input int start_again_at);
    logic [7:0] bits;
    bits = p;
    add(1'b1, 1'b1, p, c, {bits[7], 1'b1, 1'b1, 1'b0});
    for (int i = 1; i < 8; i++) begin
      add(1'b1, (i == start_again_at), p_after, c_after, {bits[7-i], 1'b1, 1'b1, 1'b0});
    end
    add(1'b1, 1'b0, p_after, c_after, 4'b0011);
    add(1'b1, 1'b0, p_after, c_after, 4'b0000);
  endfunction

  initial begin
    logic [7:0] p;
    logic [3:0] hist;
    int         hits[$];
    int         done_cnt;

    n_total = 0;
    n_pass  = 0;
    rst = 1'b0; start = 1'b0; pattern = 8'h00; count = 4'd0;

    // Reset, single burst of 8'b1001_0110
    add(1'b0, 1'b0, 8'h00, 4'd0, 4'b0000);
    add(1'b1, 1'b0, 8'h00, 4'd0, 4'b0000);
    add_burst(8'h96, 4'd1, 8'h96, 4'd1, -1);
    // Zero count: done the cycle after the start sample, valid never rises
    add(1'b1, 1'b1, 8'h55, 4'd0, 4'b0011);
    add(1'b1, 1'b0, 8'h55, 4'd0, 4'b0000);
    // Ignore while busy: restart with FF at bit 3, inputs changed afterwards
    add_burst(8'hA5, 4'd1, 8'hFF, 4'd7, 3);
    // Start held through DONE: ignored in DONE, accepted on the next edge
    add(1'b1, 1'b1, 8'h80, 4'd0, 4'b0011);
    add(1'b1, 1'b1, 8'h80, 4'd1, 4'b0000);
    add_burst(8'h80, 4'd1, 8'h80, 4'd1, -1);

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst; start = vecs[k].start;
      pattern = vecs[k].pattern; count = vecs[k].count;
      step();
      check($sformatf("vec%0d", k), {28'd0, dout, valid, busy, done}, {28'd0, vecs[k].exp});
    end

    // Repeat: count=3 gives 24 contiguous bits and one done at cycle 25
    p = 8'h96;
    done_cnt = 0;
    start = 1'b1; pattern = p; count = 4'd3;
    step();
    start = 1'b0; pattern = 8'h00; count = 4'd0;
    for (int k = 0; k < 24; k++) begin
      check($sformatf("rep_bit%0d", k), {29'd0, dout, valid, busy}, {29'd0, p[7 - (k % 8)], 2'b11});
      if (done) done_cnt++;
      step();
    end
    check("rep_done", {29'd0, valid, busy, done}, 32'd3);
    if (done) done_cnt++;
    step();
    check("rep_idle", {28'd0, dout, valid, busy, done}, 32'd0);
    check("rep_done_count", done_cnt, 32'd1);

    // Reset mid-burst during bit 4 of 8'hC3, then a clean 8'h3C burst
    start = 1'b1; pattern = 8'hC3; count = 4'd2;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("rst_pre_bit4", {30'd0, dout, valid}, 32'd1);
    rst = 1'b0;
    step();
    check("rst_outputs", {28'd0, dout, valid, busy, done}, 32'd0);
    rst = 1'b1;
    step();
    check("rst_no_done", {28'd0, dout, valid, busy, done}, 32'd0);
    p = 8'h3C;
    start = 1'b1; pattern = p; count = 4'd1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("post_rst_bit%0d", k), {29'd0, dout, valid, busy}, {29'd0, p[7-k], 2'b11});
      step();
    end
    check("post_rst_done", {28'd0, dout, valid, busy, done}, 32'd3);

    // Detector stream: target 1011 over two repetitions of 1011_0101,
    // completing at bit indices 3, 8 (across the boundary) and 11
    step();
    p = 8'hB5;
    hist = 4'd0;
    start = 1'b1; pattern = p; count = 4'd2;
    step();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (valid) begin
        hist = {hist[2:0], dout};
        if (k >= 3 && hist == 4'b1011) hits.push_back(k);
      end
      step();
    end
    check("det_hits", hits.size(), 32'd3);
    if (hits.size() == 3) begin
      check("det_hit0", hits[0], 32'd3);
      check("det_hit1", hits[1], 32'd8);
      check("det_hit2", hits[2], 32'd11);
    end
    check("det_done", {31'd0, done}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
